// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
// Latency: start accepted at edge T, done high after edge T+WIDTH for one cycle.
// Backpressure: none; start is ignored while busy, nothing is queued.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // One full-subtractor slice on the current operand LSBs.
  logic d_bit;
  logic br_nxt;
  always_comb begin
    d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  end

  // Next-state and datapath updates; results only move on the final shift.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          br_d     = bin;
          cnt_d    = '0;
          a_sign_d = a[WIDTH-1];
          b_sign_d = b[WIDTH-1];
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_nxt;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
          // The final bit shifted in is the result sign bit.
          ovf_d   = (a_sign_q != b_sign_q) & (d_bit != a_sign_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Directed vector table, multi-cycle corner sequences, then randomized ops.
// Results compared against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] ediff;
    logic         ebout;
    logic         eovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference: plain unsigned/signed integer arithmetic, {bout, ovf, diff}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rbin);
    logic [W:0] wide;
    int         s;
    logic       ovf;
    wide = {1'b0, ra} - {1'b0, rb} - (W+1)'(rbin);
    s    = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return {wide[W], ovf, wide[W-1:0]};
  endfunction

  // One operation from IDLE; returns results and the done latency in edges.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        output logic [W-1:0] rd, output logic rbo, output logic rov,
                        output int lat);
    logic [W-1:0] prev_diff;
    prev_diff = diff;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; bin = tbin;
    @(posedge clk);
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("diff_held_during_op", 32'(diff), 32'(prev_diff));
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    rd = diff; rbo = bout; rov = overflow;
    check("done_latency", 32'(lat), 32'(W));
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs[7];
  logic [W-1:0] rd;
  logic         rbo, rov;
  int           lat;
  logic [W+1:0] exp_v;
  int           done_cnt;
  int           done_at[$];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    check("reset_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, rd, rbo, rov, lat);
      check("vec_diff", 32'(rd),  32'(vecs[i].ediff));
      check("vec_bout", 32'(rbo), 32'(vecs[i].ebout));
      check("vec_ovf",  32'(rov), 32'(vecs[i].eovf));
    end
    check("idle_after_op_busy", 32'(busy), 32'd0);
    check("idle_holds_diff", 32'(diff), 32'h80);

    // start with new operands in the 3rd SHIFT cycle must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0; rd = '0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        rd = diff;
      end
    end
    check("ignore_start_done_cnt", 32'(done_cnt), 32'd1);
    check("ignore_start_diff", 32'(rd), 32'h0F);

    // Reset in the 4th SHIFT cycle aborts and clears outputs.
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h01; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h05, 8'h03, 1'b0, rd, rbo, rov, lat);
    check("post_abort_diff", 32'({rbo, rov, rd}), 32'({1'b0, 1'b0, 8'h02}));

    // start held high: one result every W+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_at.push_back(i);
        check("held_start_diff", 32'(diff), 32'h02);
      end
    end
    start = 1'b0;
    check("held_start_pulses", 32'(done_at.size()), 32'd3);
    if (done_at.size() > 0) check("held_start_first", 32'(done_at[0]), 32'(W + 1));
    for (int i = 1; i < done_at.size(); i++)
      check("held_start_period", 32'(done_at[i] - done_at[i-1]), 32'(W + 2));
    repeat (W + 4) @(posedge clk);
    #1;

    // Randomized operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (n % 16 == 0) rb = ra;
      exp_v = ref_model(ra, rb, rbin);
      run_op(ra, rb, rbin, rd, rbo, rov, lat);
      check("random_result", 32'({rbo, rov, rd}), 32'(exp_v));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
